ram_read_arbiter: RTL and testbench

RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

---
 rtl/ram_read_arbiter.sv | 107 ++++++++++
 tb/tb_ram_read_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_arbiter.sv
// Two-requester read arbiter with one write requester over a dual-port RAM.
// Port A carries writes, port B carries reads; responses are returned one cycle after acceptance.
module ram_read_arbiter #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 freeze,

    input  logic                 rd0_valid,
    input  logic [AW-1:0]        rd0_addr,
    output logic                 rd0_ready,
    input  logic                 rd1_valid,
    input  logic [AW-1:0]        rd1_addr,
    output logic                 rd1_ready,

    output logic                 rsp0_valid,
    output logic [MEM_WIDTH-1:0] rsp0_data,
    output logic                 rsp1_valid,
    output logic [MEM_WIDTH-1:0] rsp1_data,

    input  logic                 wr_valid,
    input  logic [AW-1:0]        wr_addr,
    input  logic [MEM_WIDTH-1:0] wr_data,
    output logic                 wr_ready,

    output logic                 ram_en_a,
    output logic                 ram_write_en_a,
    output logic [AW-1:0]        ram_addr_a,
    output logic [MEM_WIDTH-1:0] ram_data_in_a,

    output logic                 ram_en_b,
    output logic [AW-1:0]        ram_addr_b,
    input  logic [MEM_WIDTH-1:0] ram_data_out_b
);

    logic                 wr_fire_p0;
    logic                 haz0_p0, haz1_p0;
    logic                 elig0_p0, elig1_p0;
    logic                 gnt0_p0, gnt1_p0;
    logic                 rd_fire_p0;
    logic                 last_grant;
    logic                 vld_p1;
    logic                 tag_p1;
    logic [MEM_WIDTH-1:0] hold0_p1, hold1_p1;

    // Stage p0: write acceptance, hazard screening and read arbitration
    assign wr_ready   = ~reset;
    assign wr_fire_p0 = wr_valid & ~reset;

    // A read colliding with a same-cycle write would see stale port-B data, so it waits a cycle.
    assign haz0_p0  = wr_fire_p0 && (rd0_addr == wr_addr);
    assign haz1_p0  = wr_fire_p0 && (rd1_addr == wr_addr);
    assign elig0_p0 = rd0_valid & ~freeze & ~reset & ~haz0_p0;
    assign elig1_p0 = rd1_valid & ~freeze & ~reset & ~haz1_p0;

    always_comb begin
        gnt0_p0 = 1'b0;
        gnt1_p0 = 1'b0;
        if (elig0_p0 && elig1_p0) begin
            if (last_grant) gnt0_p0 = 1'b1;
            else            gnt1_p0 = 1'b1;
        end else begin
            gnt0_p0 = elig0_p0;
            gnt1_p0 = elig1_p0;
        end
    end

    assign rd_fire_p0 = gnt0_p0 | gnt1_p0;
    assign rd0_ready  = gnt0_p0;
    assign rd1_ready  = gnt1_p0;

    assign ram_en_a       = wr_fire_p0;
    assign ram_write_en_a = wr_fire_p0;
    assign ram_addr_a     = wr_fire_p0 ? wr_addr : '0;
    assign ram_data_in_a  = wr_fire_p0 ? wr_data : '0;

    assign ram_en_b   = rd_fire_p0;
    assign ram_addr_b = gnt1_p0 ? rd1_addr : (gnt0_p0 ? rd0_addr : '0);

    // Stage p1: pending read tracking and response delivery
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            tag_p1     <= 1'b0;
            last_grant <= 1'b1;
            hold0_p1   <= '0;
            hold1_p1   <= '0;
        end else begin
            vld_p1 <= rd_fire_p0;
            if (rd_fire_p0) begin
                tag_p1     <= gnt1_p0;
                last_grant <= gnt1_p0;
            end
            if (rsp0_valid) hold0_p1 <= ram_data_out_b;
            if (rsp1_valid) hold1_p1 <= ram_data_out_b;
        end
    end

    assign rsp0_valid = vld_p1 & ~tag_p1;
    assign rsp1_valid = vld_p1 &  tag_p1;
    assign rsp0_data  = rsp0_valid ? ram_data_out_b : hold0_p1;
    assign rsp1_data  = rsp1_valid ? ram_data_out_b : hold1_p1;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed bench for ram_read_arbiter with a behavioural dual-port RAM attached.
module tb_ram_read_arbiter;

    localparam int MW = 32;
    localparam int MD = 1024;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          freeze;
    logic          rd0_valid, rd1_valid;
    logic [AW-1:0] rd0_addr, rd1_addr;
    logic          rd0_ready, rd1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [MW-1:0] rsp0_data, rsp1_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_data;
    logic          wr_ready;
    logic          ram_en_a, ram_write_en_a, ram_en_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [MW-1:0] ram_data_in_a;
    logic [MW-1:0] ram_data_out_b = '0;

    logic [MW-1:0] mem [0:MD-1];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ram_read_arbiter #(.MEM_WIDTH(MW), .MEM_DEPTH(MD)) dut (
        .clock(clock), .reset(reset), .freeze(freeze),
        .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
        .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_en_a(ram_en_a), .ram_write_en_a(ram_write_en_a),
        .ram_addr_a(ram_addr_a), .ram_data_in_a(ram_data_in_a),
        .ram_en_b(ram_en_b), .ram_addr_b(ram_addr_b), .ram_data_out_b(ram_data_out_b)
    );

    // RAM model: port A write, port B registered read
    always @(posedge clock) begin
        if (ram_en_a && ram_write_en_a) mem[ram_addr_a] <= ram_data_in_a;
        if (ram_en_b) ram_data_out_b <= mem[ram_addr_b];
    end

    typedef struct {
        logic          frz;
        logic          r0v;
        logic [AW-1:0] r0a;
        logic          r1v;
        logic [AW-1:0] r1a;
        logic          wv;
        logic [AW-1:0] wa;
        logic [MW-1:0] wd;
        logic          e_rdy0;
        logic          e_rdy1;
        logic          e_enb;
        logic [AW-1:0] e_addrb;
        logic          e_ena;
        logic          e_v0;
        logic [MW-1:0] e_d0;
        logic          e_v1;
        logic [MW-1:0] e_d1;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".rd0_ready"},  MW'(rd0_ready), '0);
        check({tag, ".rd1_ready"},  MW'(rd1_ready), '0);
        check({tag, ".wr_ready"},   MW'(wr_ready), '0);
        check({tag, ".rsp0_valid"}, MW'(rsp0_valid), '0);
        check({tag, ".rsp1_valid"}, MW'(rsp1_valid), '0);
        check({tag, ".rsp0_data"},  rsp0_data, '0);
        check({tag, ".rsp1_data"},  rsp1_data, '0);
        check({tag, ".ram_en_a"},   MW'(ram_en_a), '0);
        check({tag, ".ram_we_a"},   MW'(ram_write_en_a), '0);
        check({tag, ".ram_en_b"},   MW'(ram_en_b), '0);
        check({tag, ".ram_addr_a"}, MW'(ram_addr_a), '0);
        check({tag, ".ram_addr_b"}, MW'(ram_addr_b), '0);
        check({tag, ".ram_din_a"},  ram_data_in_a, '0);
    endtask

    task automatic drive(input vec_t v);
        freeze    = v.frz;
        rd0_valid = v.r0v;  rd0_addr = v.r0a;
        rd1_valid = v.r1v;  rd1_addr = v.r1a;
        wr_valid  = v.wv;   wr_addr  = v.wa;  wr_data = v.wd;
    endtask

    task automatic idle();
        freeze = 0; rd0_valid = 0; rd1_valid = 0; wr_valid = 0;
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    endtask

    initial begin
        for (int i = 0; i < MD; i++) mem[i] = '0;
        mem[0] = 32'h3f16bb98;
        mem[1] = 32'h3eb4bc6a;
        mem[2] = 32'h3e41f212;
        mem[3] = 32'h3f820c49;
        mem[4] = 32'h3f020c49;
        mem[5] = 32'h3e820c49;

        //              frz r0v r0a r1v r1a wv wa  wd            rdy0 rdy1 enb addrb ena  v0 d0            v1 d1
        vq.push_back('{0, 1, 0,  1, 1,  0, 0,  32'h0,        1, 0, 1, 0,  0, 0, 32'h0,        0, 32'h0});
        vq.push_back('{0, 1, 0,  1, 1,  0, 0,  32'h0,        0, 1, 1, 1,  0, 1, 32'h3f16bb98, 0, 32'h0});
        vq.push_back('{0, 1, 0,  1, 1,  0, 0,  32'h0,        1, 0, 1, 0,  0, 0, 32'h3f16bb98, 1, 32'h3eb4bc6a});
        vq.push_back('{0, 1, 0,  1, 1,  0, 0,  32'h0,        0, 1, 1, 1,  0, 1, 32'h3f16bb98, 0, 32'h3eb4bc6a});
        vq.push_back('{0, 0, 0,  1, 2,  0, 0,  32'h0,        0, 1, 1, 2,  0, 0, 32'h3f16bb98, 1, 32'h3eb4bc6a});
        vq.push_back('{0, 0, 0,  1, 3,  0, 0,  32'h0,        0, 1, 1, 3,  0, 0, 32'h3f16bb98, 1, 32'h3e41f212});
        vq.push_back('{0, 0, 0,  1, 4,  0, 0,  32'h0,        0, 1, 1, 4,  0, 0, 32'h3f16bb98, 1, 32'h3f820c49});
        vq.push_back('{0, 0, 0,  1, 5,  0, 0,  32'h0,        0, 1, 1, 5,  0, 0, 32'h3f16bb98, 1, 32'h3f020c49});
        vq.push_back('{0, 0, 0,  0, 0,  0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 32'h3f16bb98, 1, 32'h3e820c49});
        vq.push_back('{0, 1, 10, 0, 0,  1, 10, 32'hdeadbeef, 0, 0, 0, 0,  1, 0, 32'h3f16bb98, 0, 32'h3e820c49});
        vq.push_back('{0, 1, 10, 0, 0,  0, 0,  32'h0,        1, 0, 1, 10, 0, 0, 32'h3f16bb98, 0, 32'h3e820c49});
        vq.push_back('{0, 0, 0,  0, 0,  0, 0,  32'h0,        0, 0, 0, 0,  0, 1, 32'hdeadbeef, 0, 32'h3e820c49});
        vq.push_back('{0, 0, 0,  1, 0,  0, 0,  32'h0,        0, 1, 1, 0,  0, 0, 32'hdeadbeef, 0, 32'h3e820c49});
        vq.push_back('{1, 1, 0,  1, 1,  0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 32'hdeadbeef, 1, 32'h3f16bb98});
        vq.push_back('{1, 1, 0,  1, 1,  0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 32'hdeadbeef, 0, 32'h3f16bb98});
        vq.push_back('{1, 1, 0,  1, 1,  0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 32'hdeadbeef, 0, 32'h3f16bb98});
        vq.push_back('{0, 1, 0,  1, 1,  0, 0,  32'h0,        1, 0, 1, 0,  0, 0, 32'hdeadbeef, 0, 32'h3f16bb98});
        vq.push_back('{0, 0, 0,  0, 0,  0, 0,  32'h0,        0, 0, 0, 0,  0, 1, 32'h3f16bb98, 0, 32'h3f16bb98});
        vq.push_back('{0, 1, 3,  1, 5,  1, 3,  32'h12345678, 0, 1, 1, 5,  1, 0, 32'h3f16bb98, 0, 32'h3f16bb98});
        vq.push_back('{0, 1, 3,  0, 0,  0, 0,  32'h0,        1, 0, 1, 3,  0, 0, 32'h3f16bb98, 1, 32'h3e820c49});
        vq.push_back('{0, 0, 0,  0, 0,  0, 0,  32'h0,        0, 0, 0, 0,  0, 1, 32'h12345678, 0, 32'h3e820c49});

        // Reset asserted before any clock edge, with live requests on the inputs
        reset = 0;
        idle();
        rd0_valid = 1; rd1_valid = 1; rd1_addr = 1; wr_valid = 1; wr_addr = 3; wr_data = 32'h55aa55aa;
        #2 reset = 1;
        #1 check_zero("rst_async");
        @(posedge clock);
        @(negedge clock);
        check_zero("rst_hold");
        idle();
        reset = 0;

        foreach (vq[i]) begin
            @(posedge clock);
            #1 drive(vq[i]);
            @(negedge clock);
            check($sformatf("v%0d.rd0_ready", i),  MW'(rd0_ready),  MW'(vq[i].e_rdy0));
            check($sformatf("v%0d.rd1_ready", i),  MW'(rd1_ready),  MW'(vq[i].e_rdy1));
            check($sformatf("v%0d.wr_ready", i),   MW'(wr_ready),   MW'(1'b1));
            check($sformatf("v%0d.ram_en_b", i),   MW'(ram_en_b),   MW'(vq[i].e_enb));
            check($sformatf("v%0d.ram_addr_b", i), MW'(ram_addr_b), MW'(vq[i].e_addrb));
            check($sformatf("v%0d.ram_en_a", i),   MW'(ram_en_a),   MW'(vq[i].e_ena));
            check($sformatf("v%0d.ram_we_a", i),   MW'(ram_write_en_a), MW'(vq[i].e_ena));
            check($sformatf("v%0d.rsp0_valid", i), MW'(rsp0_valid), MW'(vq[i].e_v0));
            check($sformatf("v%0d.rsp0_data", i),  rsp0_data,       vq[i].e_d0);
            check($sformatf("v%0d.rsp1_valid", i), MW'(rsp1_valid), MW'(vq[i].e_v1));
            check($sformatf("v%0d.rsp1_data", i),  rsp1_data,       vq[i].e_d1);
        end

        // Reset in the cycle after an accepted read drops the response
        @(posedge clock);
        #1 idle(); rd0_valid = 1; rd0_addr = 1;
        @(negedge clock);
        check("pre_rst.rd0_ready", MW'(rd0_ready), MW'(1'b1));
        @(posedge clock);
        #1 rd0_valid = 1; rd0_addr = 0; wr_valid = 1; wr_addr = 7; wr_data = 32'hcafef00d;
        #1 check("pre_rst.rsp0_valid", MW'(rsp0_valid), MW'(1'b1));
        check("pre_rst.rsp0_data", rsp0_data, 32'h3eb4bc6a);
        #1 reset = 1;
        #1 check_zero("mid_rst");
        @(posedge clock);
        @(negedge clock);
        check_zero("mid_rst_hold");
        idle();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("post_rst%0d.rsp0_valid", k), MW'(rsp0_valid), '0);
            check($sformatf("post_rst%0d.rsp1_valid", k), MW'(rsp1_valid), '0);
            check($sformatf("post_rst%0d.rsp0_data", k),  rsp0_data, '0);
        end

        // RAM contents survive reset; last_grant back at 1 favours requester 0
        @(posedge clock);
        #1 rd0_valid = 1; rd0_addr = 10; rd1_valid = 1; rd1_addr = 1;
        @(negedge clock);
        check("ret.rd0_ready", MW'(rd0_ready), MW'(1'b1));
        check("ret.rd1_ready", MW'(rd1_ready), MW'(1'b0));
        @(posedge clock);
        #1 idle();
        @(negedge clock);
        check("ret.rsp0_valid", MW'(rsp0_valid), MW'(1'b1));
        check("ret.rsp0_data", rsp0_data, 32'hdeadbeef);
        check("ret.mem7", mem[7], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
